// File: rtl/polar_sequencer_pkg.sv
// Shared definitions for the polar sequencer: FSM encoding, angle constants in
// 9.10 fixed-point degrees, sector thresholds and operand negation helper.
package polar_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_NORM,
        ST_OUT
    } state_t;

    localparam logic signed [19:0] DEG180  = 20'sd184320;
    localparam logic signed [19:0] DEG360  = 20'sd368640;
    localparam logic        [18:0] DEG22_5 = 19'd23040;
    localparam logic        [18:0] DEG45   = 19'd46080;

    localparam int NUM_SECTORS = 8;

    // Sector k starts at 22.5 + 45*(k-1) degrees; element 0 is the lowest boundary.
    localparam logic [NUM_SECTORS-1:0][18:0] SECTOR_THR = {
        19'd345600, 19'd299520, 19'd253440, 19'd207360,
        19'd161280, 19'd115200, 19'd69120,  19'd23040
    };

    function automatic logic signed [15:0] neg_sat(input logic signed [15:0] v);
        if (v == 16'sh8000) begin
            return 16'sh7fff;
        end
        return -v;
    endfunction

endpackage

// File: rtl/polar_sequencer_angle_sector.sv
// Maps a normalised angle in [0, 360) degrees (9.10 fixed point) to one of
// eight compass sectors centred on the axes and diagonals.
module angle_sector
    import polar_sequencer_pkg::*;
(
    input  logic [18:0] angle,
    output logic [2:0]  sector
);

    logic [NUM_SECTORS-1:0] above;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SECTORS; gi++) begin : g_thr
            assign above[gi] = (angle >= SECTOR_THR[gi]);
        end
    endgenerate

    // Counting crossed boundaries; all eight crossed wraps to 0 (the +x sector).
    always_comb begin
        sector = 3'd0;
        for (int i = 0; i < NUM_SECTORS; i++) begin
            sector = sector + {2'b00, above[i]};
        end
    end

endmodule

// File: rtl/polar_sequencer.sv
// Sequences one wind vector through an external CORDIC stage: pre-rotates the
// operands into the right half-plane, times the CORDIC run, then normalises.
module polar_sequencer
    import polar_sequencer_pkg::*;
#(
    parameter int CORDIC_LAT = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] y_in,
    output logic               cordic_start,
    output logic               cordic_enable,
    output logic signed [15:0] cordic_x,
    output logic signed [15:0] cordic_y,
    input  logic signed [18:0] cordic_angle,
    input  logic        [15:0] cordic_mod,
    output logic               out_valid,
    input  logic               out_ready,
    output logic        [18:0] out_angle,
    output logic        [15:0] out_mod,
    output logic        [2:0]  out_sector,
    output logic               busy
);

    localparam int CNT_W = (CORDIC_LAT > 1) ? $clog2(CORDIC_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CORDIC_LAT - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  quad_q, quad_d;
    logic                  zero_q, zero_d;
    logic signed [15:0]    cordic_x_q, cordic_x_d;
    logic signed [15:0]    cordic_y_q, cordic_y_d;
    logic signed [18:0]    angle_q, angle_d;
    logic        [15:0]    mod_q, mod_d;
    logic                  out_valid_q, out_valid_d;
    logic        [18:0]    out_angle_q, out_angle_d;
    logic        [15:0]    out_mod_q, out_mod_d;
    logic        [2:0]     out_sector_q, out_sector_d;

    logic signed [19:0]    norm_sum;
    logic        [18:0]    norm_angle;
    logic        [2:0]     norm_sector;

    // Undo the half-plane pre-rotation and fold into [0, 360).
    always_comb begin
        norm_sum = {angle_q[18], angle_q};
        if (quad_q) begin
            norm_sum = norm_sum + DEG180;
        end
        if (norm_sum < 20'sd0) begin
            norm_sum = norm_sum + DEG360;
        end
        if (norm_sum >= DEG360) begin
            norm_sum = norm_sum - DEG360;
        end
        norm_angle = norm_sum[18:0];
    end

    angle_sector u_angle_sector (
        .angle  (norm_angle),
        .sector (norm_sector)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        quad_d       = quad_q;
        zero_d       = zero_q;
        cordic_x_d   = cordic_x_q;
        cordic_y_d   = cordic_y_q;
        angle_d      = angle_q;
        mod_d        = mod_q;
        out_valid_d  = out_valid_q;
        out_angle_d  = out_angle_q;
        out_mod_d    = out_mod_q;
        out_sector_d = out_sector_q;
        req_ready     = 1'b0;
        cordic_start  = 1'b0;
        cordic_enable = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d    = ST_START;
                    quad_d     = x_in[15];
                    zero_d     = (x_in == 16'sd0) && (y_in == 16'sd0);
                    cordic_x_d = x_in[15] ? neg_sat(x_in) : x_in;
                    cordic_y_d = x_in[15] ? neg_sat(y_in) : y_in;
                end
            end
            ST_START: begin
                cordic_start  = 1'b1;
                cordic_enable = 1'b1;
                cnt_d         = '0;
                state_d       = ST_RUN;
            end
            ST_RUN: begin
                cordic_enable = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    angle_d = cordic_angle;
                    mod_d   = cordic_mod;
                    state_d = ST_NORM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_NORM: begin
                out_valid_d  = 1'b1;
                out_angle_d  = zero_q ? 19'd0 : norm_angle;
                out_mod_d    = zero_q ? 16'd0 : mod_q;
                out_sector_d = zero_q ? 3'd0  : norm_sector;
                state_d      = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            quad_q       <= 1'b0;
            zero_q       <= 1'b0;
            cordic_x_q   <= '0;
            cordic_y_q   <= '0;
            angle_q      <= '0;
            mod_q        <= '0;
            out_valid_q  <= 1'b0;
            out_angle_q  <= '0;
            out_mod_q    <= '0;
            out_sector_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            quad_q       <= quad_d;
            zero_q       <= zero_d;
            cordic_x_q   <= cordic_x_d;
            cordic_y_q   <= cordic_y_d;
            angle_q      <= angle_d;
            mod_q        <= mod_d;
            out_valid_q  <= out_valid_d;
            out_angle_q  <= out_angle_d;
            out_mod_q    <= out_mod_d;
            out_sector_q <= out_sector_d;
        end
    end

    assign cordic_x   = cordic_x_q;
    assign cordic_y   = cordic_y_q;
    assign out_valid  = out_valid_q;
    assign out_angle  = out_angle_q;
    assign out_mod    = out_mod_q;
    assign out_sector = out_sector_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
